// File: rtl/down_counter_timer.sv
// Loadable down-counting timer: load a start value, start, decrement on each tick,
// pulse done on expiry, then stop or (optionally) reload and keep running.
module down_counter_timer #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             tick,
    output logic [WIDTH-1:0] Q,
    output logic             running,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] start_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            q_reg      <= ZERO;
            reload_reg <= ZERO;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            q_reg      <= q_next;
            reload_reg <= reload_next;
            done_reg   <= done_next;
        end
    end

    // A start in the same cycle as a load is judged against the value being loaded.
    assign start_val = load ? load_val : q_reg;

    always_comb begin
        state_next  = state_reg;
        q_next      = q_reg;
        reload_next = reload_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    q_next      = load_val;
                    reload_next = load_val;
                end
                if (start) begin
                    if (start_val != ZERO) begin
                        state_next = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (load) begin
                    // Abort: reload silently and return to IDLE without a done pulse.
                    q_next      = load_val;
                    reload_next = load_val;
                    state_next  = IDLE;
                end else if (tick) begin
                    if (q_reg > ONE) begin
                        q_next = q_reg - ONE;
                    end else begin
                        done_next = 1'b1;
                        if (AUTO_RELOAD && (reload_reg != ZERO)) begin
                            q_next = reload_reg;
                        end else begin
                            q_next     = ZERO;
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign Q       = q_reg;
    assign running = (state_reg == RUN);
    assign done    = done_reg;

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: one one-shot and one auto-reload instance share
// directed and random stimulus and are compared cycle by cycle with a reference model.
module tb_down_counter_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       tick;
    logic [3:0] q0, q1;
    logic       r0, r1, d0, d1;

    int checks = 0;
    int errors = 0;

    // Reference state per instance: index 0 one-shot, index 1 auto-reload.
    int mq[2];
    int mrl[2];
    bit mrun[2];
    bit mdone[2];

    always #5 clk = ~clk;

    down_counter_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val),
        .start(start), .tick(tick), .Q(q0), .running(r0), .done(d0)
    );

    down_counter_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val),
        .start(start), .tick(tick), .Q(q1), .running(r1), .done(d1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0; mrl[i] = 0; mrun[i] = 1'b0; mdone[i] = 1'b0;
        end
    endtask

    // Apply one clock edge's worth of the timer rules to the reference state.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            mdone[i] = 1'b0;
            if (!mrun[i]) begin
                if (load) begin
                    mq[i] = int'(load_val);
                    mrl[i] = int'(load_val);
                end
                if (start) begin
                    if (mq[i] != 0) mrun[i] = 1'b1;
                    else mdone[i] = 1'b1;
                end
            end else if (load) begin
                mq[i] = int'(load_val);
                mrl[i] = int'(load_val);
                mrun[i] = 1'b0;
            end else if (tick) begin
                if (mq[i] > 1) begin
                    mq[i] = mq[i] - 1;
                end else begin
                    mdone[i] = 1'b1;
                    if (i == 1 && mrl[i] != 0) begin
                        mq[i] = mrl[i];
                    end else begin
                        mq[i] = 0;
                        mrun[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        check("q_oneshot", 32'(q0), 32'(mq[0]));
        check("running_oneshot", 32'(r0), 32'(mrun[0]));
        check("done_oneshot", 32'(d0), 32'(mdone[0]));
        check("q_reload", 32'(q1), 32'(mq[1]));
        check("running_reload", 32'(r1), 32'(mrun[1]));
        check("done_reload", 32'(d1), 32'(mdone[1]));
    endtask

    // Drive inputs between edges, clock once, advance the model, sample 1 ns later.
    task automatic cyc(input bit l, input int lv, input bit s, input bit t);
        load = l; load_val = lv[3:0]; start = s; tick = t;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before the next edge.
    task automatic async_reset();
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_val = 4'd0; start = 1'b0; tick = 1'b0;
        model_reset();
        #12;
        check_all();
        reset = 1'b0;

        // Load 5, start, tick held high.
        cyc(1'b1, 5, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b1);
        repeat (7) cyc(1'b0, 0, 1'b0, 1'b1);

        // Load 2 with start, tick every third cycle.
        cyc(1'b1, 2, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++) cyc(1'b0, 0, 1'b0, (k % 3) == 2);

        // Zero-length timer.
        cyc(1'b1, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 0, 1'b0, 1'b1);

        // Abort with load during ticks, then restart from the new value.
        cyc(1'b1, 9, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 0, 1'b0, 1'b1);
        cyc(1'b1, 4, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b1, 1'b1);
        repeat (6) cyc(1'b0, 0, 1'b0, 1'b1);

        // Auto-reload period of 3 (one-shot instance stops after one period).
        cyc(1'b1, 3, 1'b1, 1'b1);
        repeat (10) cyc(1'b0, 0, 1'b0, 1'b1);

        // Asynchronous reset mid-count, then tick alone must not count.
        cyc(1'b1, 6, 1'b1, 1'b0);
        async_reset();
        repeat (4) cyc(1'b0, 0, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b1, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b1);

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 600; n++) begin
            int lv;
            lv = (($urandom % 6) == 0) ? 0 : int'($urandom % 16);
            cyc(($urandom % 10) == 0, lv, ($urandom % 4) == 0, ($urandom % 3) != 0);
            if (($urandom % 80) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable countdown counter; the down-counting counterpart to the team's free-running 4-bit up counter.
- Software or an FSM loads a start value and issues start. The block decrements Q on each tick strobe.
- On reaching zero it emits a one-cycle done pulse, then either stops or auto-reloads.
- Used as the delay/timeout element in lab designs, e.g. debounce windows and display multiplex periods.

Parameters:
- WIDTH, 4, counter width in bits.
- AUTO_RELOAD, 0, if 1 the counter reloads the last loaded value on expiry and keeps running.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  captures load_val into Q and into the reload register.
- load_val  input  WIDTH  value captured by load.
- start  input  1  begins counting from the current Q.
- tick  input  1  count-enable strobe; one decrement per clk edge while high and running.
- Q  output  WIDTH  current count, registered.
- running  output  1  high while in state RUN.
- done  output  1  registered, one-cycle expiry pulse.

Behaviour:
- Reset, asynchronous and immediate even mid-count: Q=0, reload register=0, state=IDLE, running=0, done=0.
- States are IDLE and RUN. running = (state==RUN). done defaults to 0 every cycle unless set below.
- IDLE:
  - load: Q<=load_val, reload<=load_val; stays IDLE.
  - start without load: if Q!=0, go to RUN. If Q==0, stay IDLE and set done=1 for one cycle (zero-length timer).
  - load and start in the same cycle: the load takes effect. start is judged against load_val: go to RUN if load_val!=0, else pulse done.
  - tick is ignored in IDLE.
- RUN:
  - tick with Q>1: Q<=Q-1.
  - tick with Q==1 (expiry edge): done<=1.
    - AUTO_RELOAD=0: Q<=0, go to IDLE.
    - AUTO_RELOAD=1 and reload!=0: Q<=reload, stay in RUN; Q never shows 0.
    - AUTO_RELOAD=1 and reload==0 (not reachable in normal use): Q<=0, go to IDLE.
  - tick low: Q holds.
  - load (abort): Q<=load_val, reload<=load_val, go to IDLE, no done pulse. load has priority over tick in the same cycle.
  - start is ignored in RUN; it does not restart the count.
- Timing:
  - done is high for exactly the one cycle following the expiry edge. With AUTO_RELOAD=0 this coincides with the first cycle that Q==0.
  - Latency from start to the first decrement is one cycle: the decrement happens on the first tick sampled while in RUN.
- Arithmetic is modulo-free: Q never decrements below 0 and never wraps to all-ones.
- With tick tied high, the count period is load_val cycles from the RUN entry edge to the done edge.

Test Plan:
- Reset, then load_val=5 with load, then start, with tick held high → running=1 and Q steps 5,4,3,2,1,0. done=1 for exactly the one cycle in which Q first reads 0, then running=0.
- tick asserted every 3rd cycle, load_val=2, start → Q holds between ticks. done fires on the clock edge after the 2nd tick; there is no decrement while tick is low.
- load_val=0, load then start → running stays 0, done pulses once, Q stays 0.
- Abort: load_val=9, start, after 3 ticks assert load with load_val=4 and tick high → Q=4, running=0, no done pulse. A subsequent start counts down from 4.
- AUTO_RELOAD=1, load_val=3, tick high → Q sequence 3,2,1,3,2,1,…, done pulses every 3rd cycle, running stays 1, Q never reads 0.
- Assert reset asynchronously (between edges) at Q=6 while running → Q=0, running=0, done=0 immediately. After deassertion, tick alone causes no counting until load and start.
